// File: rtl/wb_int_ctrl_pkg.sv
// Shared constants for the Wishbone interrupt controller: register map, CTRL bits, widths.
// No logic, so no latency; no flow control.
// Also holds the priority encoder used to build CAUSE.
package wb_int_ctrl_pkg;

  localparam int BUS_W   = 32;
  localparam int MAX_SRC = 32;

  localparam logic [2:0] REG_PEND  = 3'd0;
  localparam logic [2:0] REG_MASK  = 3'd1;
  localparam logic [2:0] REG_MODE  = 3'd2;
  localparam logic [2:0] REG_CTRL  = 3'd3;
  localparam logic [2:0] REG_CAUSE = 3'd4;
  localparam logic [2:0] REG_RAW   = 3'd5;

  localparam int CTRL_GIE = 0;

  // Lowest set bit wins; an all-zero vector encodes as 0.
  function automatic logic [4:0] lowest_set(input logic [MAX_SRC-1:0] v);
    lowest_set = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/wb_int_ctrl_if.sv
// Single-slave Wishbone-style bus bundle for the interrupt controller.
// Carries wires only, so no latency; STB/ACK is the handshake.
// The master holds STB until ACK; back-to-back requests are acked every other cycle.
interface wb_int_ctrl_if;
  import wb_int_ctrl_pkg::*;

  logic             STB;
  logic             WE;
  logic [BUS_W-1:0] ADDR;
  logic [BUS_W-1:0] DAT_I;
  logic [BUS_W-1:0] DAT_O;
  logic             ACK;

  modport master (output STB, WE, ADDR, DAT_I, input DAT_O, ACK);
  modport slave  (input STB, WE, ADDR, DAT_I, output DAT_O, ACK);
endinterface

// File: rtl/wb_int_ctrl_src_cell.sv
// One interrupt source: synchroniser, last-value flop and level/edge pending latch.
// Latency: pending follows src SYNC_STAGES edges after src is first sampled.
// No backpressure; a W1C arriving with a new rising edge loses to the set.
module int_src_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic mode,
  input  logic w1c,
  output logic s,
  output logic pending
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      last_q  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q[0] <= src;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      last_q <= s;
      if (mode) begin
        pending <= (s & ~last_q) | (pending & ~w1c);
      end else begin
        pending <= s;
      end
    end
  end

endmodule

// File: rtl/wb_int_ctrl.sv
// Interrupt controller with MASK/MODE/CTRL registers and registered INT/CAUSE outputs.
// Latency: ACK one cycle after STB; INT/CAUSE one edge after pending or MASK/CTRL change.
// No backpressure on sources; the bus is acked every other cycle while STB is held.
module wb_int_ctrl
  import wb_int_ctrl_pkg::*;
#(
  parameter int          N_SRC       = 16,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] RESET_MASK  = 32'h0,
  parameter logic [31:0] RESET_MODE  = 32'h0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_SRC-1:0]    src,
  wb_int_ctrl_if.slave        bus,
  output logic                INT,
  output logic [BUS_W-1:0]    CAUSE
);

  logic [N_SRC-1:0]   mask_q;
  logic [N_SRC-1:0]   mode_q;
  logic               gie_q;
  logic [N_SRC-1:0]   s_vec;
  logic [N_SRC-1:0]   pend_vec;
  logic [N_SRC-1:0]   w1c;
  logic               acc;
  logic               wr;
  logic [2:0]         sel;
  logic [BUS_W-1:0]   rd_data;
  logic [MAX_SRC-1:0] act;
  logic               unused_bits;

  assign acc = bus.STB & ~bus.ACK;
  assign wr  = acc & bus.WE;
  assign sel = bus.ADDR[4:2];

  assign unused_bits = ^{bus.ADDR[31:5], bus.ADDR[1:0], bus.DAT_I};

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    int_src_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk     (clk),
      .rst     (rst),
      .src     (src[i]),
      .mode    (mode_q[i]),
      .w1c     (w1c[i]),
      .s       (s_vec[i]),
      .pending (pend_vec[i])
    );
  end

  always_comb begin
    w1c = '0;
    if (wr && sel == REG_PEND) w1c = bus.DAT_I[N_SRC-1:0];
  end

  always_comb begin
    act = '0;
    act[N_SRC-1:0] = pend_vec & mask_q;
  end

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_PEND:  rd_data[N_SRC-1:0] = pend_vec;
      REG_MASK:  rd_data[N_SRC-1:0] = mask_q;
      REG_MODE:  rd_data[N_SRC-1:0] = mode_q;
      REG_CTRL:  rd_data[CTRL_GIE]  = gie_q;
      REG_CAUSE: rd_data            = CAUSE;
      REG_RAW:   rd_data[N_SRC-1:0] = s_vec;
      default:   rd_data            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q    <= RESET_MASK[N_SRC-1:0];
      mode_q    <= RESET_MODE[N_SRC-1:0];
      gie_q     <= 1'b0;
      bus.ACK   <= 1'b0;
      bus.DAT_O <= '0;
      INT       <= 1'b0;
      CAUSE     <= '0;
    end else begin
      bus.ACK   <= acc;
      bus.DAT_O <= (acc & ~bus.WE) ? rd_data : '0;
      if (wr) begin
        case (sel)
          REG_MASK: mask_q <= bus.DAT_I[N_SRC-1:0];
          REG_MODE: mode_q <= bus.DAT_I[N_SRC-1:0];
          REG_CTRL: gie_q  <= bus.DAT_I[CTRL_GIE];
          default:  ;
        endcase
      end
      // CAUSE reflects masked pending even while GIE is off.
      INT   <= gie_q & (|act);
      CAUSE <= {27'd0, lowest_set(act)};
    end
  end

endmodule

// File: tb/tb_wb_int_ctrl.sv
// Directed and randomized bench for wb_int_ctrl against a vector-level reference model.
module tb_wb_int_ctrl;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  src;
  logic          INT;
  logic [31:0]   CAUSE;
  logic [31:0]   d;

  wb_int_ctrl_if bus();

  wb_int_ctrl #(
    .N_SRC(N), .SYNC_STAGES(2), .RESET_MASK(32'h0), .RESET_MODE(32'h0)
  ) dut (
    .clk(clk), .rst(rst), .src(src), .bus(bus), .INT(INT), .CAUSE(CAUSE)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [N-1:0] m_s1, m_s2, m_last, m_pend, m_mask, m_mode;
  logic         m_gie, m_int, m_ack;
  logic [31:0]  m_cause, m_dato;
  bit           m_valid = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_cause(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) begin
      if (a[i]) return 32'(i);
    end
    return 32'd0;
  endfunction

  // Advance one clock edge, step the model with the inputs seen at that edge, compare outputs.
  task automatic tick();
    logic [N-1:0] in_src, s, w1c, rise, n_pend;
    logic         in_rst, in_stb, in_we, acc, wr;
    logic [31:0]  in_addr, in_dati, rd;
    logic [2:0]   sel;
    in_src = src; in_rst = rst; in_stb = bus.STB; in_we = bus.WE;
    in_addr = bus.ADDR; in_dati = bus.DAT_I;
    @(posedge clk);
    #1;
    if (in_rst) begin
      m_s1 = '0; m_s2 = '0; m_last = '0; m_pend = '0;
      m_mask = '0; m_mode = '0; m_gie = 1'b0;
      m_int = 1'b0; m_cause = '0; m_ack = 1'b0; m_dato = '0;
      m_valid = 1;
    end else begin
      acc  = in_stb & ~m_ack;
      wr   = acc & in_we;
      sel  = in_addr[4:2];
      s    = m_s2;
      w1c  = (wr && sel == 3'd0) ? in_dati[N-1:0] : '0;
      rise = s & ~m_last;
      case (sel)
        3'd0: rd = 32'(m_pend);
        3'd1: rd = 32'(m_mask);
        3'd2: rd = 32'(m_mode);
        3'd3: rd = {31'd0, m_gie};
        3'd4: rd = m_cause;
        3'd5: rd = 32'(s);
        default: rd = 32'd0;
      endcase
      n_pend  = (m_mode & (rise | (m_pend & ~w1c))) | (~m_mode & s);
      m_int   = m_gie && ((m_pend & m_mask) != '0);
      m_cause = ref_cause(m_pend & m_mask);
      m_dato  = (acc && !in_we) ? rd : 32'd0;
      m_ack   = acc;
      if (wr && sel == 3'd1) m_mask = in_dati[N-1:0];
      if (wr && sel == 3'd2) m_mode = in_dati[N-1:0];
      if (wr && sel == 3'd3) m_gie  = in_dati[0];
      m_pend = n_pend;
      m_last = s;
      m_s2   = m_s1;
      m_s1   = in_src;
    end
    if (m_valid) begin
      check("ack",   {31'd0, bus.ACK}, {31'd0, m_ack});
      check("dat_o", bus.DAT_O, m_dato);
      check("int",   {31'd0, INT}, {31'd0, m_int});
      check("cause", CAUSE, m_cause);
    end
  endtask

  task automatic wb_write(input logic [31:0] a, input logic [31:0] v);
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = a; bus.DAT_I = v;
    tick();
    check("wr_ack", {31'd0, bus.ACK}, 32'd1);
    bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
  endtask

  task automatic wb_read(input logic [31:0] a, output logic [31:0] v);
    bus.STB = 1'b1; bus.WE = 1'b0; bus.ADDR = a; bus.DAT_I = 32'd0;
    tick();
    check("rd_ack", {31'd0, bus.ACK}, 32'd1);
    v = bus.DAT_O;
    bus.STB = 1'b0;
    tick();
    check("rd_ack_drop", {31'd0, bus.ACK}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; src = '0;
    bus.STB = 1'b0; bus.WE = 1'b0; bus.ADDR = '0; bus.DAT_I = '0;
    tick(); tick();
    rst = 1'b0;
    check("rst_int", {31'd0, INT}, 32'd0);
    check("rst_cause", CAUSE, 32'd0);
    wb_read(32'h00, d); check("rst_pend", d, 32'd0);
    wb_read(32'h04, d); check("rst_mask", d, 32'd0);
    wb_read(32'h08, d); check("rst_mode", d, 32'd0);
    wb_read(32'h0C, d); check("rst_ctrl", d, 32'd0);

    // Level source latency and priority.
    wb_write(32'h04, 32'h28);
    wb_write(32'h0C, 32'h1);
    src = 16'h0008;
    tick(); tick(); tick();
    check("lvl_int_early", {31'd0, INT}, 32'd0);
    tick();
    check("lvl_int", {31'd0, INT}, 32'd1);
    check("lvl_cause3", CAUSE, 32'd3);
    src = 16'h0028; repeat (4) tick();
    check("lvl_cause_keep3", CAUSE, 32'd3);
    src = 16'h0020; repeat (4) tick();
    check("lvl_cause5", CAUSE, 32'd5);
    src = '0; repeat (4) tick();

    // Edge source with W1C.
    wb_write(32'h08, 32'h1);
    wb_write(32'h04, 32'h1);
    src = 16'h0001; tick(); src = '0;
    repeat (4) tick();
    wb_read(32'h00, d); check("edge_pend", d, 32'h1);
    check("edge_int", {31'd0, INT}, 32'd1);
    wb_write(32'h00, 32'h1);
    check("w1c_int", {31'd0, INT}, 32'd0);

    // Rising edge lands on the same edge as the W1C.
    src = 16'h0001; tick(); src = '0; repeat (4) tick();
    src = 16'h0001; tick(); src = '0; tick();
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = 32'h00; bus.DAT_I = 32'h1;
    tick();
    bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
    wb_read(32'h00, d); check("set_wins", d, 32'h1);
    wb_write(32'h00, 32'h1);
    wb_read(32'h00, d); check("w1c_clear", d, 32'h0);

    // Mask and global enable.
    wb_write(32'h08, 32'h4);
    wb_write(32'h04, 32'h0);
    src = 16'h0004; tick(); src = '0; repeat (4) tick();
    wb_read(32'h00, d); check("mg_pend", d, 32'h4);
    check("mg_int_masked", {31'd0, INT}, 32'd0);
    check("mg_cause_masked", CAUSE, 32'd0);
    wb_write(32'h0C, 32'h0);
    wb_write(32'h04, 32'h4);
    tick();
    check("mg_int_nogie", {31'd0, INT}, 32'd0);
    check("mg_cause_nogie", CAUSE, 32'd2);
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = 32'h0C; bus.DAT_I = 32'h1;
    tick();
    check("gie_at_ack", {31'd0, INT}, 32'd0);
    bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
    check("gie_int", {31'd0, INT}, 32'd1);

    // Reset during a bus cycle.
    bus.STB = 1'b1; bus.WE = 1'b1; bus.ADDR = 32'h04; bus.DAT_I = 32'hFFFF;
    rst = 1'b1;
    tick();
    check("rst_mid_ack", {31'd0, bus.ACK}, 32'd0);
    rst = 1'b0; bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
    wb_read(32'h04, d); check("rst_mid_mask", d, 32'h0);

    // Unmapped and read-only addresses.
    wb_read(32'h18, d); check("unmapped_rd", d, 32'h0);
    wb_write(32'h10, 32'hFFFF);
    wb_write(32'h1C, 32'hFFFF);
    wb_read(32'h04, d); check("ro_mask", d, 32'h0);
    wb_read(32'h08, d); check("ro_mode", d, 32'h0);
    wb_read(32'h0C, d); check("ro_ctrl", d, 32'h0);
    wb_read(32'h1C, d); check("unmapped_rd7", d, 32'h0);

    // Randomized traffic, including held STB and occasional reset.
    for (int it = 0; it < 800; it++) begin
      rst = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 2) == 0) src = N'($urandom);
      if (!bus.STB || $urandom_range(0, 2) == 0) begin
        bus.STB   = 1'($urandom_range(0, 1));
        bus.WE    = 1'($urandom_range(0, 1));
        bus.ADDR  = $urandom;
        bus.DAT_I = $urandom;
      end
      tick();
    end

    rst = 1'b0; src = '0; bus.STB = 1'b0; bus.WE = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
